beat_track_controller: RTL and testbench

BEAT_TRACK_CONTROLLER -- requirements
Module: beat_track_controller

---
 rtl/beat_track_controller.sv | 147 ++++++++++++++
 tb/tb_beat_track_controller.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/beat_track_controller.sv
// Beat track controller: records timed key events into a small buffer and
// replays them through the shared key_out path to the tone player.
module beat_track_controller #(
  parameter int DEPTH = 64,
  parameter int TS_W  = 16
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      tick,
  input  logic [6:0]                live_key,
  input  logic                      rec_start,
  input  logic                      play_start,
  input  logic                      stop,
  output logic [6:0]                key_out,
  output logic                      is_record,
  output logic [1:0]                state,
  output logic                      full,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int ENT_W = 7 + TS_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RECORD = 2'b01,
    S_PLAY   = 2'b10
  } state_t;

  state_t st, st_nxt;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [TS_W-1:0]  delta_cnt;
  logic [TS_W-1:0]  wait_cnt;
  logic [6:0]       prev_key;
  logic [CNT_W-1:0] play_idx;

  logic             clr_rec;
  logic             start_play;
  logic             rec_step;
  logic             play_step;
  logic             is_event;
  logic             store_ok;
  logic             play_busy;
  logic             emit;
  logic [6:0]       rd_key;
  logic [TS_W-1:0]  rd_delta;

  function automatic logic [TS_W-1:0] sat_inc(input logic [TS_W-1:0] v,
                                              input logic            inc);
    if (inc && (v != '1))
      return v + TS_W'(1);
    return v;
  endfunction

  assign {rd_key, rd_delta} = mem[play_idx[AW-1:0]];

  assign full      = (count == CNT_W'(DEPTH));
  assign is_record = (st == S_RECORD);
  assign state     = st;

  // stop outranks rec_start, which outranks play_start; a pre-empted state does no work
  assign clr_rec    = !stop && rec_start;
  assign rec_step   = (st == S_RECORD) && !stop && !rec_start;
  assign play_step  = (st == S_PLAY) && !stop && !rec_start;
  assign start_play = (st == S_IDLE) && !stop && !rec_start && play_start && (count != '0);

  assign is_event  = rec_step && (live_key != prev_key);
  assign store_ok  = is_event && !full;
  assign play_busy = (play_idx < count);
  assign emit      = play_step && play_busy && (wait_cnt >= rd_delta);

  always_ff @(posedge clock) begin
    if (!resetn)
      st <= S_IDLE;
    else
      st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    if (stop)
      st_nxt = S_IDLE;
    else if (rec_start)
      st_nxt = S_RECORD;
    else begin
      case (st)
        S_IDLE:   if (start_play) st_nxt = S_PLAY;
        S_RECORD: st_nxt = S_RECORD;
        S_PLAY:   if (!play_busy) st_nxt = S_IDLE;
        default:  st_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      key_out   <= '0;
      count     <= '0;
      delta_cnt <= '0;
      prev_key  <= '0;
      play_idx  <= '0;
      wait_cnt  <= '0;
    end else begin
      // key_out mirrors the keyboard except while the track owns the player
      if (st != S_PLAY)
        key_out <= live_key;
      else if (emit)
        key_out <= rd_key;

      if (clr_rec) begin
        count     <= '0;
        delta_cnt <= '0;
        prev_key  <= '0;
      end else if (rec_step) begin
        if (is_event) begin
          prev_key  <= live_key;
          delta_cnt <= '0;
          if (store_ok)
            count <= count + CNT_W'(1);
        end else begin
          delta_cnt <= sat_inc(delta_cnt, tick);
        end
      end

      if (start_play) begin
        play_idx <= '0;
        wait_cnt <= '0;
      end else if (play_step && play_busy) begin
        if (emit) begin
          play_idx <= play_idx + CNT_W'(1);
          wait_cnt <= '0;
        end else begin
          wait_cnt <= sat_inc(wait_cnt, tick);
        end
      end
    end
  end

  // The tick that lands on an event cycle still counts toward that event's delta
  always_ff @(posedge clock) begin
    if (resetn && store_ok)
      mem[count[AW-1:0]] <= {live_key, sat_inc(delta_cnt, tick)};
  end

endmodule

// File: tb/tb_beat_track_controller.sv
// Directed bench for beat_track_controller: record, playback, full buffer,
// control priority, delta saturation and reset during playback.
module tb_beat_track_controller;

  localparam int DEPTH = 64;
  localparam int TS_W  = 16;

  logic                   clock = 1'b0;
  logic                   resetn;
  logic                   tick;
  logic [6:0]             live_key;
  logic                   rec_start;
  logic                   play_start;
  logic                   stop;
  logic [6:0]             key_out;
  logic                   is_record;
  logic [1:0]             state;
  logic                   full;
  logic [$clog2(DEPTH):0] count;

  int checks = 0;
  int errors = 0;
  logic [7+TS_W-1:0] ent;

  beat_track_controller #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .tick       (tick),
    .live_key   (live_key),
    .rec_start  (rec_start),
    .play_start (play_start),
    .stop       (stop),
    .key_out    (key_out),
    .is_record  (is_record),
    .state      (state),
    .full       (full),
    .count      (count)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    resetn = 1'b0; tick = 1'b0; live_key = 7'h00;
    rec_start = 1'b0; play_start = 1'b0; stop = 1'b0;
    cyc(); cyc();
    check("rst_state", 32'(state), 32'h0);
    check("rst_key_out", 32'(key_out), 32'h0);
    check("rst_count", 32'(count), 32'h0);
    check("rst_full", 32'(full), 32'h0);
    check("rst_is_record", 32'(is_record), 32'h0);
    resetn = 1'b1;

    // idle follows keyboard with one cycle latency
    live_key = 7'h35;
    cyc();
    check("idle_follow", 32'(key_out), 32'h35);
    live_key = 7'h00;
    play_start = 1'b1;
    cyc();
    play_start = 1'b0;
    check("play_empty_ignored", 32'(state), 32'h0);

    // basic record: 3 ticks, key 0x61, 5 ticks, key 0
    rec_start = 1'b1;
    cyc();
    rec_start = 1'b0;
    check("rec_state", 32'(state), 32'h1);
    check("rec_is_record", 32'(is_record), 32'h1);
    check("rec_count0", 32'(count), 32'h0);
    tick = 1'b1;
    repeat (3) cyc();
    tick = 1'b0; live_key = 7'h61;
    cyc();
    check("rec_count1", 32'(count), 32'h1);
    check("rec_key_follow", 32'(key_out), 32'h61);
    tick = 1'b1;
    repeat (5) cyc();
    tick = 1'b0; live_key = 7'h00;
    cyc();
    check("rec_count2", 32'(count), 32'h2);
    ent = dut.mem[0];
    check("rec_entry0", 32'(ent), {9'd0, 7'h61, 16'd3});
    ent = dut.mem[1];
    check("rec_entry1", 32'(ent), {9'd0, 7'h00, 16'd5});
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    check("stop_idle", 32'(state), 32'h0);
    check("stop_keeps_count", 32'(count), 32'h2);

    // playback; live_key must not leak to key_out
    play_start = 1'b1;
    cyc();
    play_start = 1'b0;
    check("play_state", 32'(state), 32'h2);
    live_key = 7'h7a;
    tick = 1'b1;
    repeat (3) cyc();
    tick = 1'b0;
    check("play_before_emit", 32'(key_out), 32'h0);
    cyc();
    check("play_emit0", 32'(key_out), 32'h61);
    tick = 1'b1;
    repeat (5) cyc();
    tick = 1'b0;
    check("play_hold", 32'(key_out), 32'h61);
    cyc();
    check("play_emit1", 32'(key_out), 32'h00);
    check("play_still_play", 32'(state), 32'h2);
    cyc();
    check("play_done_idle", 32'(state), 32'h0);
    cyc();
    check("idle_resume_follow", 32'(key_out), 32'h7a);
    live_key = 7'h00;

    // tick coincides with an event: stored delta 5, counter cleared
    rec_start = 1'b1;
    cyc();
    rec_start = 1'b0;
    tick = 1'b1;
    repeat (4) cyc();
    check("delta_at4", 32'(dut.delta_cnt), 32'd4);
    live_key = 7'h11;
    cyc();
    tick = 1'b0;
    ent = dut.mem[0];
    check("same_cycle_delta", 32'(ent[TS_W-1:0]), 32'd5);
    check("same_cycle_clear", 32'(dut.delta_cnt), 32'd0);
    check("same_cycle_count", 32'(count), 32'd1);

    // stop and rec_start together during playback
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    play_start = 1'b1;
    cyc();
    play_start = 1'b0;
    check("prio_in_play", 32'(state), 32'h2);
    stop = 1'b1; rec_start = 1'b1;
    cyc();
    stop = 1'b0; rec_start = 1'b0;
    check("prio_state", 32'(state), 32'h0);
    check("prio_count", 32'(count), 32'd1);

    // buffer full: DEPTH+3 distinct key changes
    live_key = 7'h00;
    rec_start = 1'b1;
    cyc();
    rec_start = 1'b0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      live_key = 7'(i + 1);
      cyc();
    end
    check("full_count", 32'(count), 32'd64);
    check("full_flag", 32'(full), 32'h1);
    check("full_state", 32'(state), 32'h1);
    ent = dut.mem[DEPTH-1];
    check("full_last_key", 32'(ent[7+TS_W-1:TS_W]), 32'd64);
    play_start = 1'b1;
    cyc();
    play_start = 1'b0;
    check("play_in_rec_ignored", 32'(state), 32'h1);

    // delta saturation over 70000 ticks
    live_key = 7'h00;
    rec_start = 1'b1;
    cyc();
    rec_start = 1'b0;
    check("sat_cleared", 32'(full), 32'h0);
    tick = 1'b1;
    repeat (70000) cyc();
    check("sat_counter", 32'(dut.delta_cnt), 32'd65535);
    live_key = 7'h22;
    cyc();
    tick = 1'b0;
    ent = dut.mem[0];
    check("sat_stored", 32'(ent[TS_W-1:0]), 32'd65535);
    check("sat_count", 32'(count), 32'd1);

    // reset during playback overrides pulses
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    play_start = 1'b1;
    cyc();
    play_start = 1'b0;
    check("rp_in_play", 32'(state), 32'h2);
    tick = 1'b1;
    repeat (3) cyc();
    tick = 1'b0;
    check("rp_key_before", 32'(key_out), 32'h22);
    resetn = 1'b0; play_start = 1'b1;
    cyc();
    resetn = 1'b1;
    check("rp_state", 32'(state), 32'h0);
    check("rp_key_out", 32'(key_out), 32'h0);
    check("rp_count", 32'(count), 32'h0);
    cyc();
    play_start = 1'b0;
    check("rp_play_ignored", 32'(state), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
